ad_frame_packer: RTL



---
 rtl/ad_frame_packer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ad_frame_packer.sv
// Store-and-forward framer: captures an A/D acquisition window into a buffer RAM, then
// streams header (sync, id, count), payload and a peak/overflow trailer on valid/ready.
module ad_frame_packer #(
  parameter int               DSIZE      = 16,
  parameter int               DEPTH_LOG2 = 10,
  parameter logic [DSIZE-1:0] SYNC       = 16'hA55A
) (
  input  logic             i_ad_clk,
  input  logic             i_rst,
  input  logic [DSIZE-1:0] i_dual_data,
  input  logic             i_data_on,
  input  logic             i_working,
  output logic [DSIZE-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_frame_drop
);

  localparam int HALF  = DSIZE / 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WCW   = DEPTH_LOG2 + 1;
  localparam int IW    = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SEND} state_t;

  state_t               state_q, state_d;
  logic                 work_q, work_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic [HALF-1:0]      peak_q, peak_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          id_q, id_d;
  logic [IW-1:0]        nxt_q, nxt_d;
  logic [DSIZE-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;

  logic [DSIZE-1:0]     mem [DEPTH];
  logic [DSIZE-1:0]     rdata_q;
  logic [DEPTH_LOG2-1:0] mem_addr, raddr;
  logic                 mem_we;

  logic                 rise, fall, qual, load, done;
  logic [IW-1:0]        n_words, last_idx;
  logic [DSIZE-1:0]     word_sel;

  function automatic logic [HALF-1:0] peak_of(input logic [HALF-1:0] p,
                                               input logic [DSIZE-1:0] w);
    logic [HALF-1:0] m;
    m = p;
    if (w[HALF-1:0] > m)     m = w[HALF-1:0];
    if (w[DSIZE-1:HALF] > m) m = w[DSIZE-1:HALF];
    return m;
  endfunction

  assign rise     = i_working & ~work_q;
  assign fall     = ~i_working & work_q;
  assign qual     = i_working & i_data_on;
  assign n_words  = IW'(wcnt_q) + IW'(4);
  assign last_idx = IW'(wcnt_q) + IW'(3);
  assign load     = (state_q == S_SEND) && (nxt_q < n_words) && (!valid_q || i_ready);
  assign done     = (state_q == S_SEND) && valid_q && i_ready && last_q;

  // Word offered next: header fields, the trailer, or the prefetched RAM word.
  always_comb begin
    word_sel = '0;
    if (nxt_q == IW'(0)) begin
      word_sel = SYNC;
    end else if (nxt_q == IW'(1)) begin
      word_sel[15:0] = id_q;
    end else if (nxt_q == IW'(2)) begin
      word_sel[WCW-1:0] = wcnt_q;
    end else if (nxt_q == last_idx) begin
      word_sel[DSIZE-1]  = ovf_q;
      word_sel[HALF-1:0] = peak_q;
    end else begin
      word_sel = rdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = i_working;
    wcnt_d  = wcnt_q;
    peak_d  = peak_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    nxt_d   = nxt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_CAPTURE;
          wcnt_d  = '0;
          peak_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (qual) begin
          if (!wcnt_q[WCW-1]) wcnt_d = wcnt_q + WCW'(1);
          else                ovf_d  = 1'b1;
          peak_d = peak_of(peak_q, i_dual_data);
        end
        if (fall) begin
          state_d = S_SEND;
          nxt_d   = '0;
        end
      end
      S_SEND: begin
        if (rise) drop_d = 1'b1;
        if (done) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          id_d    = id_q + 16'd1;
        end else if (load) begin
          data_d  = word_sel;
          valid_d = 1'b1;
          last_d  = (nxt_q == last_idx);
          nxt_d   = nxt_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // The read issued now targets the word loaded at the next handshake, so
  // the RAM latency never shows up as a bubble on the stream.
  assign raddr    = DEPTH_LOG2'(nxt_d - IW'(3));
  assign mem_addr = (state_q == S_CAPTURE) ? wcnt_q[DEPTH_LOG2-1:0] : raddr;
  assign mem_we   = (state_q == S_CAPTURE) && qual && !wcnt_q[WCW-1];

  always_ff @(posedge i_ad_clk) begin
    if (mem_we) mem[mem_addr] <= i_dual_data;
    rdata_q <= mem[mem_addr];
  end

  always_ff @(posedge i_ad_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      work_q  <= 1'b1;
      wcnt_q  <= '0;
      peak_q  <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
      nxt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      wcnt_q  <= wcnt_d;
      peak_q  <= peak_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      nxt_q   <= nxt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_busy       = busy_q;
  assign o_frame_drop = drop_q;

endmodule
